// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, baud divider
// calculation and legal parameter ranges.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

  localparam int OS_MIN        = 8;
  localparam int OS_MAX        = 32;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MAX = 2;
  localparam int DIV_MIN       = 2;

  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk tick every DIV clocks, with a
// synchronous clear to re-phase the count against an external event.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < DIV_MIN) begin : g_div_chk
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable width/stop bits and error flags.
// Optional parity checker is built when UART_RX_PARITY_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int DIV  = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      SB_LAST = 4'(STOP_BITS - 1);

  if (OVERSAMPLE < OS_MIN || OVERSAMPLE > OS_MAX || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and within 8..32");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_db_chk
    $error("uart_rx_os: DATA_BITS must be within 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > STOP_BITS_MAX) begin : g_sb_chk
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  logic sync1_q, sync2_q, prev_q;
  logic fall, tick, tick_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  uart_rx_state_e         state_q;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic [3:0]             bc_q;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   frm_err_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   valid_q, frame_err_q;

  assign fall       = prev_q & ~sync2_q;
  assign tick_clear = (state_q == ST_IDLE) && fall;
  assign sc_d       = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
  assign shift_d    = {sync2_q, shift_q[DATA_BITS-1:1]};

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (tick_clear),
    .tick_o  (tick)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_err_q, parity_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sc_q        <= '0;
      bc_q        <= '0;
      shift_q     <= '0;
      frm_err_q   <= 1'b0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            sc_q    <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sc_q == SC_HALF) begin
              if (sync2_q) begin
                state_q <= ST_IDLE;
              end else begin
                // Re-zero sc so every later wrap lands mid-bit
                sc_q      <= '0;
                bc_q      <= '0;
                frm_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_err_q <= 1'b0;
`endif
                state_q   <= ST_DATA;
              end
            end else begin
              sc_q <= sc_d;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            sc_q <= sc_d;
            if (sc_q == SC_LAST) begin
              shift_q <= shift_d;
              if (bc_q == DB_LAST) begin
                bc_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                bc_q <= bc_q + 1'b1;
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            sc_q <= sc_d;
            if (sc_q == SC_LAST) begin
              par_err_q <= sync2_q ^ (^shift_q) ^ PAR_ODD;
              state_q   <= ST_STOP;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            sc_q <= sc_d;
            if (sc_q == SC_LAST) begin
              if (bc_q == SB_LAST) begin
                rx_data_q   <= shift_q;
                frame_err_q <= frm_err_q | ~sync2_q;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_err_q;
`endif
                valid_q     <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                bc_q      <= bc_q + 1'b1;
                frm_err_q <= frm_err_q | ~sync2_q;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and a 7-bit/2-stop instance.
// Parity cases are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1536000;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int BIT_CLK  = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       v0, v1, fe0, fe1, pe0, pe1, b0, b1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx0), .rx_data(data0), .valid(v0),
    .frame_err(fe0), .parity_err(pe0), .busy(b0)
  );

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)
  ) dut7 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_data(data1), .valid(v1),
    .frame_err(fe1), .parity_err(pe1), .busy(b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic drive(input int ch, input logic b, input int nclk);
    if (ch == 0) rx0 = b;
    else         rx1 = b;
    repeat (nclk) @(negedge clk);
  endtask

  // Pushes the expected result, then drives one complete frame.
  task automatic send(input int ch, input logic [8:0] d, input int nbits, input int nstops,
                      input logic stop_lvl, input logic par_flip,
                      input logic exp_fe, input logic exp_pe);
    exp_t e;
    logic p;
    e.d  = d;
    e.fe = exp_fe;
    e.pe = exp_pe;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
    p = par_flip;
    drive(ch, 1'b0, BIT_CLK);
    for (int i = 0; i < nbits; i++) begin
      p = p ^ d[i];
      drive(ch, d[i], BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    drive(ch, p, BIT_CLK);
`endif
    for (int s = 0; s < nstops; s++) drive(ch, stop_lvl, BIT_CLK);
    if (ch == 0) rx0 = 1'b1;
    else         rx1 = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && v0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid0 actual=%0h required=none", data0);
      end else begin
        e = q0.pop_front();
        chk("rx_data0", {24'd0, data0}, {23'd0, e.d});
        chk("frame_err0", {31'd0, fe0}, {31'd0, e.fe});
        chk("parity_err0", {31'd0, pe0}, {31'd0, e.pe});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && v1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid1 actual=%0h required=none", data1);
      end else begin
        e = q1.pop_front();
        chk("rx_data1", {25'd0, data1}, {23'd0, e.d});
        chk("frame_err1", {31'd0, fe1}, {31'd0, e.fe});
        chk("parity_err1", {31'd0, pe1}, {31'd0, e.pe});
      end
    end
  end

  initial begin
    exp_t brk;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, v0}, 32'd0);
    chk("reset_rx_data", {24'd0, data0}, 32'd0);
    chk("reset_frame_err", {31'd0, fe0}, 32'd0);
    chk("reset_parity_err", {31'd0, pe0}, 32'd0);
    chk("reset_busy", {31'd0, b0}, 32'd0);
    drive(0, 1'b1, BIT_CLK);

    send(0, 9'h0A5, 8, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, BIT_CLK);
    chk("busy_after_A5", {31'd0, b0}, 32'd0);

    // Glitch shorter than half a bit must be rejected at the start sample.
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 20);
    chk("busy_during_glitch", {31'd0, b0}, 32'd1);
    drive(0, 1'b1, 200);
    chk("busy_after_glitch", {31'd0, b0}, 32'd0);
    send(0, 9'h03C, 8, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, BIT_CLK);

    send(0, 9'h055, 8, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1, BIT_CLK);
    send(0, 9'h00F, 8, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, BIT_CLK);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity bit is 1, so sending 0 is an error.
    send(0, 9'h007, 8, 1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b1, BIT_CLK);
    send(0, 9'h007, 8, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, BIT_CLK);
`endif

    send(1, 9'h041, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1, 9'h07F, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b1, BIT_CLK);
    chk("busy1_after_b2b", {31'd0, b1}, 32'd0);

    // Abort a frame mid-data with an asynchronous reset.
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    drive(0, 1'b0, BIT_CLK * 3 / 2);
    #3;
    rst = 1'b1;
    rx0 = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, v0}, 32'd0);
    chk("midrst_rx_data", {24'd0, data0}, 32'd0);
    chk("midrst_frame_err", {31'd0, fe0}, 32'd0);
    chk("midrst_busy", {31'd0, b0}, 32'd0);
    chk("midrst_rx_data1", {25'd0, data1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 12 * BIT_CLK);
    chk("busy_after_midrst", {31'd0, b0}, 32'd0);

    // 2 ms break: one errored all-zero word, then silence while low.
    brk.d  = 9'h000;
    brk.fe = 1'b1;
    brk.pe = 1'b0;
    q0.push_back(brk);
    drive(0, 1'b0, 3072);
    drive(0, 1'b0, 10 * BIT_CLK);
    chk("busy_in_break", {31'd0, b0}, 32'd0);
    chk("break_delivered", q0.size(), 32'd0);
    drive(0, 1'b1, 2 * BIT_CLK);
    send(0, 9'h0A5, 8, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 2 * BIT_CLK);

    chk("pending0", q0.size(), 32'd0);
    chk("pending1", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
